// File: rtl/uart_reg_responder.sv
// Serial register responder: decodes 'W'/'R' command frames from uart_rx and answers each frame with one byte via uart_tx.
// TX handshake: o_TxValid rises with a stable o_TxByte and is held until the i_TxDone pulse; a one-cycle GAP follows.
module uart_reg_responder #(
    parameter int         NUM_REGS       = 16,
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] RESET_VALUE    = 8'h00
) (
    input  logic       i_SysClock,
    input  logic       i_Reset,
    input  logic [7:0] i_RxByte,
    input  logic       i_RxDone,
    output logic [7:0] o_TxByte,
    output logic       o_TxValid,
    input  logic       i_TxDone,
    output logic       o_WrStrobe,
    output logic [7:0] o_WrAddr,
    output logic [7:0] o_WrData,
    output logic [7:0] o_Reg0,
    output logic       o_Overrun,
    output logic       o_Busy
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = $clog2(NUM_REGS);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RPL_OK    = 8'h4B;
    localparam logic [7:0] RPL_ERR   = 8'h45;
    localparam logic [7:0] RPL_UNK   = 8'h3F;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_DATA = 3'd2,
        SEND     = 3'd3,
        GAP      = 3'd4
    } state_t;

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic            is_write, is_write_n;
    logic [7:0]      addr_q, addr_n;
    logic [7:0]      tx_byte, tx_byte_n;
    logic            tx_valid, tx_valid_n;
    logic            overrun_n;
    logic            wr_en;
    logic            rx_addr_ok;
    logic            addr_q_ok;
    logic [7:0]      rd_reply;
    logic [7:0]      regs [NUM_REGS];

    // Full 8-bit compare so out-of-range addresses never alias onto a real register.
    assign rx_addr_ok = ({24'd0, i_RxByte} < NUM_REGS);
    assign addr_q_ok  = ({24'd0, addr_q} < NUM_REGS);
    assign rd_reply   = rx_addr_ok ? regs[i_RxByte[IW-1:0]] : RPL_ERR;

    always_comb begin
        state_n    = state;
        timer_n    = timer;
        is_write_n = is_write;
        addr_n     = addr_q;
        tx_byte_n  = tx_byte;
        tx_valid_n = tx_valid;
        overrun_n  = 1'b0;
        wr_en      = 1'b0;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (i_RxDone) begin
                    if (i_RxByte == CMD_WRITE || i_RxByte == CMD_READ) begin
                        is_write_n = (i_RxByte == CMD_WRITE);
                        state_n    = GET_ADDR;
                    end else begin
                        tx_byte_n  = RPL_UNK;
                        tx_valid_n = 1'b1;
                        state_n    = SEND;
                    end
                end
            end
            GET_ADDR: begin
                if (i_RxDone) begin
                    timer_n = '0;
                    addr_n  = i_RxByte;
                    if (is_write) begin
                        state_n = GET_DATA;
                    end else begin
                        tx_byte_n  = rd_reply;
                        tx_valid_n = 1'b1;
                        state_n    = SEND;
                    end
                end else if (timer == TW'(TIMEOUT_CYCLES)) begin
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            GET_DATA: begin
                if (i_RxDone) begin
                    timer_n    = '0;
                    wr_en      = addr_q_ok;
                    tx_byte_n  = addr_q_ok ? RPL_OK : RPL_ERR;
                    tx_valid_n = 1'b1;
                    state_n    = SEND;
                end else if (timer == TW'(TIMEOUT_CYCLES)) begin
                    timer_n = '0;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            SEND: begin
                overrun_n = i_RxDone;
                if (i_TxDone) begin
                    tx_valid_n = 1'b0;
                    state_n    = GAP;
                end
            end
            GAP: begin
                overrun_n = i_RxDone;
                state_n   = IDLE;
            end
            default: begin
                tx_valid_n = 1'b0;
                state_n    = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            state      <= IDLE;
            timer      <= '0;
            is_write   <= 1'b0;
            addr_q     <= 8'h00;
            tx_byte    <= 8'h00;
            tx_valid   <= 1'b0;
            o_Overrun  <= 1'b0;
            o_WrStrobe <= 1'b0;
            o_WrAddr   <= 8'h00;
            o_WrData   <= 8'h00;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= RESET_VALUE;
            end
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            is_write   <= is_write_n;
            addr_q     <= addr_n;
            tx_byte    <= tx_byte_n;
            tx_valid   <= tx_valid_n;
            o_Overrun  <= overrun_n;
            o_WrStrobe <= wr_en;
            if (wr_en) begin
                o_WrAddr              <= addr_q;
                o_WrData              <= i_RxByte;
                regs[addr_q[IW-1:0]]  <= i_RxByte;
            end
        end
    end

    assign o_TxByte  = tx_byte;
    assign o_TxValid = tx_valid;
    assign o_Reg0    = regs[0];
    assign o_Busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_reg_responder.sv
// Directed bench for uart_reg_responder: table of command frames plus hand-written overrun, timeout and reset sequences.
module tb_uart_reg_responder;

    logic       clk;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_done;
    logic       wr_strobe;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] reg0;
    logic       overrun;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_reg_responder #(
        .NUM_REGS       (16),
        .TIMEOUT_CYCLES (100),
        .RESET_VALUE    (8'h00)
    ) dut (
        .i_SysClock (clk),
        .i_Reset    (rst),
        .i_RxByte   (rx_byte),
        .i_RxDone   (rx_done),
        .o_TxByte   (tx_byte),
        .o_TxValid  (tx_valid),
        .i_TxDone   (tx_done),
        .o_WrStrobe (wr_strobe),
        .o_WrAddr   (wr_addr),
        .o_WrData   (wr_data),
        .o_Reg0     (reg0),
        .o_Overrun  (overrun),
        .o_Busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int         n;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        logic [7:0] exp;
        bit         wr;
        logic [7:0] wa;
        logic [7:0] wd;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte has been clocked in.
    task automatic send_byte(input logic [7:0] b);
        rx_byte = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        rx_byte = 8'h00;
    endtask

    task automatic finish_reply(input string name);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        check({name, " valid_drop"}, {7'd0, tx_valid}, 8'd0);
        check({name, " gap_busy"}, {7'd0, busy}, 8'd1);
        @(negedge clk);
        check({name, " idle"}, {7'd0, busy}, 8'd0);
    endtask

    task automatic do_frame(input string name, input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] exp, input bit wr,
                            input logic [7:0] wa, input logic [7:0] wd);
        send_byte(b0);
        if (n > 1) begin
            @(negedge clk);
            send_byte(b1);
        end
        if (n > 2) begin
            @(negedge clk);
            send_byte(b2);
        end
        check({name, " valid"}, {7'd0, tx_valid}, 8'd1);
        check({name, " reply"}, tx_byte, exp);
        check({name, " strobe"}, {7'd0, wr_strobe}, {7'd0, wr});
        if (wr) begin
            check({name, " wr_addr"}, wr_addr, wa);
            check({name, " wr_data"}, wr_data, wd);
            if (wa == 8'h00) check({name, " reg0"}, reg0, wd);
        end
        @(negedge clk);
        check({name, " strobe_low"}, {7'd0, wr_strobe}, 8'd0);
        check({name, " held"}, {7'd0, tx_valid}, 8'd1);
        check({name, " reply_held"}, tx_byte, exp);
        finish_reply(name);
    endtask

    initial begin
        int seen;

        vecs[0] = '{3, 8'h57, 8'h03, 8'hA5, 8'h4B, 1'b1, 8'h03, 8'hA5};
        vecs[1] = '{2, 8'h52, 8'h03, 8'h00, 8'hA5, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{3, 8'h57, 8'h00, 8'h3C, 8'h4B, 1'b1, 8'h00, 8'h3C};
        vecs[3] = '{2, 8'h52, 8'h10, 8'h00, 8'h45, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{3, 8'h57, 8'hFF, 8'h11, 8'h45, 1'b0, 8'h00, 8'h00};
        vecs[5] = '{1, 8'h41, 8'h00, 8'h00, 8'h3F, 1'b0, 8'h00, 8'h00};
        vecs[6] = '{3, 8'h57, 8'h0F, 8'h77, 8'h4B, 1'b1, 8'h0F, 8'h77};
        vecs[7] = '{2, 8'h52, 8'h0F, 8'h00, 8'h77, 1'b0, 8'h00, 8'h00};
        vecs[8] = '{2, 8'h52, 8'h00, 8'h00, 8'h3C, 1'b0, 8'h00, 8'h00};

        rst     = 1'b1;
        rx_byte = 8'h00;
        rx_done = 1'b0;
        tx_done = 1'b0;
        repeat (3) @(negedge clk);
        check("rst tx_valid", {7'd0, tx_valid}, 8'd0);
        check("rst tx_byte", tx_byte, 8'h00);
        check("rst busy", {7'd0, busy}, 8'd0);
        check("rst strobe", {7'd0, wr_strobe}, 8'd0);
        check("rst overrun", {7'd0, overrun}, 8'd0);
        check("rst reg0", reg0, 8'h00);
        check("rst wr_addr", wr_addr, 8'h00);
        check("rst wr_data", wr_data, 8'h00);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            do_frame($sformatf("vec%0d", i), vecs[i].n, vecs[i].b0, vecs[i].b1, vecs[i].b2,
                     vecs[i].exp, vecs[i].wr, vecs[i].wa, vecs[i].wd);
            @(negedge clk);
        end

        // Overrun while a reply is pending.
        send_byte(8'h52);
        @(negedge clk);
        send_byte(8'h03);
        check("ovr reply", tx_byte, 8'hA5);
        rx_byte = 8'h52;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        check("ovr pulse", {7'd0, overrun}, 8'd1);
        check("ovr valid", {7'd0, tx_valid}, 8'd1);
        @(negedge clk);
        check("ovr pulse_end", {7'd0, overrun}, 8'd0);
        check("ovr reply_kept", tx_byte, 8'hA5);
        finish_reply("ovr");

        // RX and TX completion in the same cycle.
        send_byte(8'h41);
        check("sim reply", tx_byte, 8'h3F);
        rx_byte = 8'h52;
        rx_done = 1'b1;
        tx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        tx_done = 1'b0;
        check("sim overrun", {7'd0, overrun}, 8'd1);
        check("sim valid_drop", {7'd0, tx_valid}, 8'd0);
        check("sim gap_busy", {7'd0, busy}, 8'd1);
        @(negedge clk);
        check("sim idle", {7'd0, busy}, 8'd0);
        check("sim overrun_end", {7'd0, overrun}, 8'd0);
        do_frame("sim read", 2, 8'h52, 8'h03, 8'h00, 8'hA5, 1'b0, 8'h00, 8'h00);

        // Reset clears register 0 and the rest of the file.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("reg0 after rst", reg0, 8'h00);
        @(negedge clk);
        do_frame("rd0 after rst", 2, 8'h52, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        do_frame("rd3 after rst", 2, 8'h52, 8'h03, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);

        // Timeout discards a partial write.
        do_frame("wr2", 3, 8'h57, 8'h02, 8'h99, 8'h4B, 1'b1, 8'h02, 8'h99);
        send_byte(8'h57);
        @(negedge clk);
        send_byte(8'h02);
        check("to busy", {7'd0, busy}, 8'd1);
        seen = 0;
        repeat (150) begin
            @(negedge clk);
            if (tx_valid || wr_strobe) seen++;
        end
        check("to idle", {7'd0, busy}, 8'd0);
        check("to no_reply", 8'(seen), 8'd0);
        do_frame("to read", 2, 8'h52, 8'h02, 8'h00, 8'h99, 1'b0, 8'h00, 8'h00);

        // Slow frame: every accepted byte restarts the idle count.
        send_byte(8'h57);
        repeat (80) @(negedge clk);
        send_byte(8'h02);
        repeat (80) @(negedge clk);
        send_byte(8'h55);
        check("slow valid", {7'd0, tx_valid}, 8'd1);
        check("slow reply", tx_byte, 8'h4B);
        check("slow strobe", {7'd0, wr_strobe}, 8'd1);
        check("slow wr_data", wr_data, 8'h55);
        @(negedge clk);
        finish_reply("slow");
        do_frame("slow read", 2, 8'h52, 8'h02, 8'h00, 8'h55, 1'b0, 8'h00, 8'h00);

        // Reset in GET_DATA, then in SEND.
        send_byte(8'h57);
        @(negedge clk);
        send_byte(8'h01);
        check("mid busy", {7'd0, busy}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid valid", {7'd0, tx_valid}, 8'd0);
        check("mid busy_rst", {7'd0, busy}, 8'd0);
        @(negedge clk);
        send_byte(8'h41);
        check("send valid", {7'd0, tx_valid}, 8'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("send valid_rst", {7'd0, tx_valid}, 8'd0);
        check("send busy_rst", {7'd0, busy}, 8'd0);
        check("send byte_rst", tx_byte, 8'h00);
        @(negedge clk);
        do_frame("rd1 after rst", 2, 8'h52, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
